// File: rtl/strobe_sequencer.sv
// Multi-channel strobe generator: a programmable-period counter feeds CHANNELS compare units.
// Define STROBE_SEQ_SHADOW_EN to latch period/cmp at each period boundary instead of reading them live.
module strobe_sequencer #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      oneshot,
    input  logic                      start,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] cmp,
    input  logic [CHANNELS-1:0]       chan_en,
    output logic [WIDTH-1:0]          count,
    output logic [CHANNELS-1:0]       strobe,
    output logic                      wrap,
    output logic                      busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]                state_reg;
    logic [WIDTH-1:0]          count_reg;
    logic [CHANNELS-1:0]       strobe_reg;
    logic                      wrap_reg;

    logic [WIDTH-1:0]          period_eff;
    logic [CHANNELS*WIDTH-1:0] cmp_eff;
    logic [CHANNELS-1:0]       match;
    logic                      running;
    logic                      terminal;
    logic                      start_run;

    assign running   = (state_reg == ST_RUN) && en;
    // >= rather than == so a period reduced below the current count still wraps
    assign terminal  = (count_reg >= period_eff);
    assign start_run = (state_reg == ST_IDLE) && en && (!oneshot || start);

`ifdef STROBE_SEQ_SHADOW_EN
    logic [WIDTH-1:0]          period_sh_reg;
    logic [CHANNELS*WIDTH-1:0] cmp_sh_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh_reg <= '0;
            cmp_sh_reg    <= '0;
        end else if (start_run || (running && terminal)) begin
            period_sh_reg <= period;
            cmp_sh_reg    <= cmp;
        end
    end

    assign period_eff = period_sh_reg;
    assign cmp_eff    = cmp_sh_reg;
`else
    assign period_eff = period;
    assign cmp_eff    = cmp;
`endif

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
            assign match[gi] = chan_en[gi] && (count_reg == cmp_eff[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            strobe_reg <= '0;
            wrap_reg   <= 1'b0;
        end else begin
            strobe_reg <= '0;
            wrap_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    count_reg <= '0;
                    if (start_run) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (running) begin
                        strobe_reg <= match;
                        wrap_reg   <= terminal;
                        if (terminal) begin
                            count_reg <= '0;
                            if (oneshot) begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign count  = count_reg;
    assign strobe = strobe_reg;
    assign wrap   = wrap_reg;
    assign busy   = (state_reg == ST_RUN);

endmodule

// File: tb/tb_strobe_sequencer.sv
// Directed self-checking bench for strobe_sequencer (WIDTH=8, CHANNELS=4).
module tb_strobe_sequencer;
    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           oneshot = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   period = '0;
    logic [C*W-1:0] cmp = '0;
    logic [C-1:0]   chan_en = '0;
    logic [W-1:0]   count;
    logic [C-1:0]   strobe;
    logic           wrap;
    logic           busy;

    int checks = 0;
    int failures = 0;

`ifdef STROBE_SEQ_SHADOW_EN
    localparam int SHR_N = 16;
    int shr_tbl [SHR_N] = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 0, 1, 2, 3, 4, 0};
`else
    localparam int SHR_N = 7;
    int shr_tbl [SHR_N] = '{0, 1, 2, 3, 4, 0, 1};
`endif

    strobe_sequencer #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .oneshot(oneshot), .start(start),
        .period(period), .cmp(cmp), .chan_en(chan_en),
        .count(count), .strobe(strobe), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cmp(input int c0, input int c1, input int c2, input int c3);
        cmp = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endtask

    // {wrap, strobe} packed for compact comparisons
    function automatic logic [31:0] outs();
        return {27'd0, wrap, strobe};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec;
        logic [31:0] eo;

        // free-running, period 11
        oneshot = 1'b0; period = 8'd11; set_cmp(7, 11, 12, 0); chan_en = 4'b0111; en = 1'b1;
        apply_reset();
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            ec = (i - 1) % 12;
            eo = 0;
            if (i >= 13 && ec == 0) eo = eo | 32'b10010;
            if (ec == 8) eo = eo | 32'b00001;
            check("fr_count", count, ec);
            check("fr_busy", busy, 1);
            check("fr_outs", outs(), eo);
            $display("free-run cycle %0d count=%0d outs=%05b", i, count, outs());
        end

        // asynchronous reset at count 9
        for (int k = 0; k < 40 && count != 8'd9; k++) @(negedge clk);
        check("rr_wait", count, 9);
        #2 rst_n = 1'b0;
        #1;
        check("rr_count", count, 0);
        check("rr_busy", busy, 0);
        check("rr_outs", outs(), 0);
        $display("async reset mid-run count=%0d busy=%0d", count, busy);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_restart", count, k);
            check("rr_rbusy", busy, 1);
        end

        // pause at count 3 with a matching compare on channel 0
        en = 1'b0; set_cmp(3, 11, 12, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("pz_count", count, 3);
            check("pz_outs", outs(), 0);
            check("pz_busy", busy, 1);
        end
        en = 1'b1;
        @(negedge clk);
        check("pz_resume", count, 4);
        check("pz_rstrb", outs(), 1);
        $display("pause resume count=%0d outs=%05b", count, outs());

        // one-shot, period 5, second start during run
        oneshot = 1'b1; period = 8'd5; chan_en = 4'b0000; start = 1'b0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("os_idle", busy, 0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("os_start_busy", busy, 1);
        check("os_start_cnt", count, 0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("os_busy", busy, 1);
            check("os_count", count, i);
            check("os_nowrap", wrap, 0);
            if (i == 2) start = 1'b1;
        end
        @(negedge clk);
        check("os_end_busy", busy, 0);
        check("os_end_cnt", count, 0);
        check("os_end_wrap", wrap, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("os_after_busy", busy, 0);
            check("os_after_wrap", wrap, 0);
            check("os_after_cnt", count, 0);
        end
        $display("one-shot done busy=%0d count=%0d", busy, count);

        // period shrink 20 -> 4 at count 10
        oneshot = 1'b0; period = 8'd20; chan_en = 4'b0000;
        apply_reset();
        for (int k = 0; k < 11; k++) @(negedge clk);
        check("shr_pre", count, 10);
        period = 8'd4;
        for (int i = 0; i < SHR_N; i++) begin
            @(negedge clk);
            check("shr_count", count, shr_tbl[i]);
            check("shr_wrap", wrap, (shr_tbl[i] == 0) ? 1 : 0);
            $display("shrink step %0d count=%0d wrap=%0d", i, count, wrap);
        end

        // zero period
        period = 8'd0; set_cmp(0, 0, 0, 0); chan_en = 4'b0001;
        apply_reset();
        @(negedge clk);
        check("zp_first_busy", busy, 1);
        check("zp_first_outs", outs(), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("zp_outs", outs(), 32'b10001);
            check("zp_count", count, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
